poll_response_collector: RTL

Consumer of the rotating one-hot polling strobes in the USB hub: on each new poll it checks whether the polled downstream port is requesting service. If it is, the collector grants that port and forwards its data burst, one beat at a time, to the single upstream stream. It sits between the downstream port engines and the upstream packet path, and is the receiving end of the polling strobe vector.

---
 rtl/usb_hub_poll_pkg.sv | 19 +
 rtl/poll_index_encoder.sv | 23 ++
 rtl/poll_response_collector.sv | 126 ++++++++++++
 3 files changed

// File: rtl/usb_hub_poll_pkg.sv
// Shared definitions for the hub polling path: collector state encoding and
// the one-hot legality check, also used by the polling strobe generator.
package usb_hub_poll_pkg;

    // Widest poll vector the legality check accepts; callers zero-extend.
    localparam int POLL_MAX_PORTS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } poll_state_t;

    // A poll is legal when exactly one strobe bit is set.
    function automatic logic poll_is_legal(input logic [POLL_MAX_PORTS-1:0] vec);
        return (vec != '0) && ((vec & (vec - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/poll_index_encoder.sv
// One-hot poll vector to binary port index, plus a flag saying whether the
// vector was a legal (single-bit) poll. Purely combinational.
module poll_index_encoder
    import usb_hub_poll_pkg::*;
#(
    parameter int NUMBER_OF_PORTS = 4
) (
    input  logic [NUMBER_OF_PORTS-1:0]         onehot,
    output logic [$clog2(NUMBER_OF_PORTS)-1:0] index,
    output logic                               legal
);
    localparam int ID_WIDTH = $clog2(NUMBER_OF_PORTS);

    // OR together the indices of set bits; only meaningful when legal is high.
    always_comb begin
        index = '0;
        for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
            if (onehot[i]) index = index | ID_WIDTH'(i);
        end
        legal = poll_is_legal(POLL_MAX_PORTS'(onehot));
    end

endmodule

// File: rtl/poll_response_collector.sv
// Receives the rotating poll strobe, grants the polled port when it has a
// burst pending and forwards that burst beat by beat to the upstream stream
// through a single output register. A stalled port is aborted after
// TIMEOUT_CYCLES consecutive idle cycles.
module poll_response_collector
    import usb_hub_poll_pkg::*;
#(
    parameter int NUMBER_OF_PORTS = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES  = 30
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUMBER_OF_PORTS-1:0]            poll_strobe,
    input  logic [NUMBER_OF_PORTS-1:0]            port_req,
    input  logic [NUMBER_OF_PORTS*DATA_WIDTH-1:0] port_data,
    input  logic [NUMBER_OF_PORTS-1:0]            port_valid,
    input  logic [NUMBER_OF_PORTS-1:0]            port_last,
    output logic [NUMBER_OF_PORTS-1:0]            port_ready,
    output logic [DATA_WIDTH-1:0]                 up_data,
    output logic                                  up_valid,
    output logic                                  up_last,
    output logic [$clog2(NUMBER_OF_PORTS)-1:0]    up_port_id,
    input  logic                                  up_ready,
    output logic                                  busy,
    output logic                                  poll_error
);
    localparam int ID_WIDTH    = $clog2(NUMBER_OF_PORTS);
    localparam int STALL_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    // The abort fires on the stall cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [STALL_WIDTH-1:0] STALL_LIMIT = STALL_WIDTH'(TIMEOUT_CYCLES - 1);

    poll_state_t                 state, state_next;
    logic [NUMBER_OF_PORTS-1:0]  poll_prev;
    logic [STALL_WIDTH-1:0]      stall_count;
    logic [ID_WIDTH-1:0]         poll_index;
    logic                        poll_legal;
    logic                        new_poll, grant, bad_poll;
    logic                        sel_valid, sel_last, up_free, accept, timeout;
    logic [DATA_WIDTH-1:0]       port_data_arr [NUMBER_OF_PORTS];

    for (genvar i = 0; i < NUMBER_OF_PORTS; i++) begin : g_unpack
        assign port_data_arr[i] = port_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    poll_index_encoder #(.NUMBER_OF_PORTS(NUMBER_OF_PORTS)) u_encoder (
        .onehot (poll_strobe),
        .index  (poll_index),
        .legal  (poll_legal)
    );

    // Poll detection and handshake qualifiers for the currently granted port.
    always_comb begin
        new_poll  = (poll_strobe != poll_prev) && (poll_strobe != '0);
        grant     = (state == ST_IDLE) && new_poll && poll_legal && port_req[poll_index];
        bad_poll  = (state == ST_IDLE) && new_poll && !poll_legal;
        sel_valid = port_valid[up_port_id];
        sel_last  = port_last[up_port_id];
        up_free   = !up_valid || up_ready;
        accept    = (state == ST_XFER) && sel_valid && up_free;
        timeout   = (state == ST_XFER) && !sel_valid && (stall_count == STALL_LIMIT);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state: grant on a fresh legal poll, leave XFER on last beat or abort,
    // leave DRAIN once the final beat has been handed upstream.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (grant) state_next = ST_XFER;
            ST_XFER: begin
                if (timeout)                 state_next = ST_IDLE;
                else if (accept && sel_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: if (up_valid && up_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: only the granted port sees ready, and only
    // when the upstream register can take a beat this cycle.
    always_comb begin
        busy       = (state != ST_IDLE);
        port_ready = '0;
        if ((state == ST_XFER) && up_free) port_ready[up_port_id] = 1'b1;
    end

    // Poll history, granted port id, stall counter and error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            poll_prev   <= '0;
            up_port_id  <= '0;
            stall_count <= '0;
            poll_error  <= 1'b0;
        end else begin
            poll_prev  <= poll_strobe;
            poll_error <= bad_poll || timeout;
            if (grant) up_port_id <= poll_index;
            if ((state != ST_XFER) || accept)
                stall_count <= '0;
            else if (!sel_valid)
                stall_count <= stall_count + STALL_WIDTH'(1);
        end
    end

    // Upstream output register: load on accept, hold until upstream takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            up_valid <= 1'b0;
            up_last  <= 1'b0;
            up_data  <= '0;
        end else if (accept) begin
            up_valid <= 1'b1;
            up_last  <= sel_last;
            up_data  <= port_data_arr[up_port_id];
        end else if (up_ready) begin
            up_valid <= 1'b0;
        end
    end

endmodule
